lcd_bus_reader: RTL and testbench

HD44780 read-cycle engine for the DE2 character LCD, the read direction of the bus that `LCD_Display` writes. It runs single status or data reads (RW=1), or polls the busy flag until it clears, and returns the byte with a done pulse. It sits beside `LCD_Display` under `top`. While `busy` is high, `top` gives it LCD_RS/LCD_RW/LCD_EN and keeps LCD_DATA high-Z.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_phase_timer.sv | 27 ++
 rtl/lcd_bus_reader.sv | 132 +++++++++++++
 tb/tb_lcd_bus_reader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the DE2 character-LCD bus engines.
//   lcd_state_e      : read-cycle phase
//   LCD_*_CYCLES     : default HD44780 bus timing at 50 MHz, also used by LCD_Display
//   BF_BIT           : busy-flag position in a status read
//   lcd_cnt_w()      : counter width able to hold values 0..n-1 (never below 1)
//   lcd_max4()       : largest of four cycle counts
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD,
    RECOVER
  } lcd_state_e;

  localparam int LCD_SETUP_CYCLES   = 4;
  localparam int LCD_ENABLE_CYCLES  = 16;
  localparam int LCD_HOLD_CYCLES    = 4;
  localparam int LCD_RECOVER_CYCLES = 12;
  localparam int LCD_POLL_LIMIT     = 4096;

  localparam int BF_BIT = 7;

  function automatic int lcd_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lcd_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter for bus phase timing.
//   clock, reset : system clock, synchronous active-high reset
//   load         : load load_value this cycle (takes priority over counting)
//   load_value   : cycles-1 of the phase being entered
//   tc           : count is zero, i.e. this is the last cycle of the phase
// The count stops at zero so tc stays asserted until the next load.
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_value;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle engine: single status/data reads or busy-flag polling.
//   clock, reset : system clock, synchronous active-high reset
//   start        : command strobe, only looked at while idle
//   rs_select    : 0 status/address read, 1 data read (forced to 0 by poll)
//   poll         : repeat status reads until BF clears or POLL_LIMIT reads
//   lcd_data_in  : LCD_DATA sampled from the pad
//   lcd_rs/rw/en : LCD bus controls, valid while busy
//   busy         : engine owns the bus
//   done         : one-cycle completion pulse
//   read_data    : last byte sampled, held until the next sample
//   timed_out    : the last poll ended with BF still set
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES   = LCD_SETUP_CYCLES,
  parameter int ENABLE_CYCLES  = LCD_ENABLE_CYCLES,
  parameter int HOLD_CYCLES    = LCD_HOLD_CYCLES,
  parameter int RECOVER_CYCLES = LCD_RECOVER_CYCLES,
  parameter int POLL_LIMIT     = LCD_POLL_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_select,
  input  logic       poll,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] read_data,
  output logic       timed_out
);

  localparam int TW  = lcd_cnt_w(lcd_max4(SETUP_CYCLES, ENABLE_CYCLES,
                                          HOLD_CYCLES, RECOVER_CYCLES));
  localparam int PCW = $clog2(POLL_LIMIT + 1);

  localparam logic [TW-1:0]  T_SETUP   = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0]  T_ENABLE  = TW'(ENABLE_CYCLES - 1);
  localparam logic [TW-1:0]  T_HOLD    = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  T_RECOVER = TW'(RECOVER_CYCLES - 1);
  localparam logic [PCW-1:0] P_LIMIT   = PCW'(POLL_LIMIT);

  lcd_state_e     state, next_state;
  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tc;
  logic           rs_q, poll_q;
  logic [PCW-1:0] poll_count;
  logic           repoll;
  logic           access;

  lcd_phase_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_val),
    .tc         (tc)
  );

  // Decided at the end of RECOVER; read_data already holds this read's byte.
  assign repoll = poll_q && read_data[BF_BIT] && (poll_count < P_LIMIT);

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      IDLE: if (start) begin
        next_state = SETUP;   tmr_load = 1'b1; tmr_val = T_SETUP;
      end
      SETUP: if (tc) begin
        next_state = ENABLE;  tmr_load = 1'b1; tmr_val = T_ENABLE;
      end
      ENABLE: if (tc) begin
        next_state = HOLD;    tmr_load = 1'b1; tmr_val = T_HOLD;
      end
      HOLD: if (tc) begin
        next_state = RECOVER; tmr_load = 1'b1; tmr_val = T_RECOVER;
      end
      RECOVER: if (tc) begin
        tmr_load = 1'b1;
        if (repoll) begin
          next_state = SETUP; tmr_val = T_SETUP;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      poll_count <= '0;
      read_data  <= 8'h00;
      timed_out  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      if (state == IDLE && start) begin
        rs_q       <= rs_select & ~poll;
        poll_q     <= poll;
        timed_out  <= 1'b0;
        poll_count <= '0;
      end
      if (state == ENABLE && tc) begin
        read_data <= lcd_data_in;
        if (poll_count != P_LIMIT) poll_count <= poll_count + 1'b1;
      end
      if (state == RECOVER && tc && !repoll) begin
        done      <= 1'b1;
        timed_out <= poll_q & read_data[BF_BIT];
      end
    end
  end

  // Controls decode straight from state so RS/RW cannot move while EN is high
  // and a reset drops EN as soon as the state register clears.
  assign access = (state == SETUP) || (state == ENABLE) || (state == HOLD);
  assign lcd_en = (state == ENABLE);
  assign lcd_rw = access;
  assign lcd_rs = access & rs_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_lcd_bus_reader.sv
module tb_lcd_bus_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, rs_select, poll;
  logic [7:0] lcd_data_in;
  logic       lcd_rs, lcd_rw, lcd_en, busy, done, timed_out;
  logic [7:0] read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         cyc;
    int         pulses;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] resp_q[$];

  always #5 clock = ~clock;

  lcd_bus_reader #(.POLL_LIMIT(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .rs_select   (rs_select),
    .poll        (poll),
    .lcd_data_in (lcd_data_in),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_en      (lcd_en),
    .busy        (busy),
    .done        (done),
    .read_data   (read_data),
    .timed_out   (timed_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command; the bus shape is checked cycle by cycle against a 36-cycle
  // read frame (setup 1-4, enable 5-20, hold 21-24, recover 25-36).
  task automatic run(input string nm, input logic rs, input logic pl,
                     input int glitch, input logic [7:0] e_data,
                     input logic e_to, input int e_pulses);
    exp_t e;
    int   viol, pulses, done_cyc, extra, p;
    logic prev_en, x_en, x_rw, x_rs, x_busy;
    sb.push_back('{data: e_data, to: e_to, cyc: e_pulses * 36 + 1, pulses: e_pulses});
    lcd_data_in = resp_q[0];
    @(negedge clock);
    start = 1'b1; rs_select = rs; poll = pl;
    @(posedge clock);
    #1 start = 1'b0; rs_select = ~rs; poll = ~pl;
    viol = 0; pulses = 0; done_cyc = 0; prev_en = 1'b0;
    for (int n = 1; n <= 400 && done_cyc == 0; n++) begin
      @(negedge clock);
      p      = ((n - 1) % 36) + 1;
      x_busy = (n <= e_pulses * 36);
      x_en   = x_busy && p >= 5 && p <= 20;
      x_rw   = x_busy && p <= 24;
      x_rs   = x_rw && rs && !pl;
      if (lcd_en !== x_en || lcd_rw !== x_rw || lcd_rs !== x_rs || busy !== x_busy)
        viol++;
      if (lcd_en && !prev_en) pulses++;
      if (prev_en && !lcd_en && resp_q.size() > 1) void'(resp_q.pop_front());
      lcd_data_in = resp_q[0];
      prev_en = lcd_en;
      if (n == glitch) start = 1'b1;
      if (n == glitch + 1) start = 1'b0;
      if (done === 1'b1) done_cyc = n;
    end
    if (done_cyc == 0) begin
      chk({nm, "_done_seen"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_done_cyc"}, done_cyc, e.cyc);
      chk({nm, "_pulses"}, pulses, e.pulses);
      chk({nm, "_data"}, read_data, e.data);
      chk({nm, "_timed_out"}, timed_out, e.to);
      chk({nm, "_proto"}, viol, 0);
    end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done || busy) extra++;
    end
    chk({nm, "_quiet_after"}, extra, 0);
  endtask

  task automatic reset_mid_access();
    int extra;
    @(negedge clock);
    start = 1'b1; rs_select = 1'b0; poll = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
    for (int n = 1; n <= 12; n++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_en", lcd_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rw", lcd_rw, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_data", read_data, 8'h00);
    reset = 1'b0;
    extra = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (done || busy) extra++;
    end
    chk("rst_mid_no_done", extra, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rs_select = 1'b0; poll = 1'b0; lcd_data_in = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_en", lcd_en, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", read_data, 8'h00);
    chk("rst_timed_out", timed_out, 0);

    resp_q = '{8'h25};
    run("status", 1'b0, 1'b0, 0, 8'h25, 1'b0, 1);
    resp_q = '{8'h41};
    run("data", 1'b1, 1'b0, 0, 8'h41, 1'b0, 1);
    resp_q = '{8'h80, 8'h80, 8'h80, 8'h07};
    run("poll_clear", 1'b1, 1'b1, 0, 8'h07, 1'b0, 4);
    resp_q = '{8'hFF};
    run("poll_timeout", 1'b0, 1'b1, 0, 8'hFF, 1'b1, 5);
    resp_q = '{8'h3C};
    run("ign_start", 1'b1, 1'b0, 10, 8'h3C, 1'b0, 1);
    reset_mid_access();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
